// File: rtl/button_pkg.sv
// button_pkg: shared event encoding and width helpers for the button event arbiter.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_REPEAT  = 2'd2
  } evt_type_t;

  localparam int EVT_TYPE_W = 2;

  // Width of a counter that must hold values 0..max_value.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: one button's synchronizer, tick-sampled debouncer, edge
// detector and, when BUTTON_AUTO_REPEAT_EN is defined, the hold/repeat counter.
// Strobes are combinational so the arbiter's pending bit lands one cycle after
// the debounced level changes.
module btn_conditioner
  import button_pkg::*;
#(
  parameter int DB_LEN = 4
`ifdef BUTTON_AUTO_REPEAT_EN
  ,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic tick,
  output logic level,
  output logic press_set,
  output logic release_set
`ifdef BUTTON_AUTO_REPEAT_EN
  ,
  output logic repeat_set
`endif
);

  localparam int DB_W = cnt_width(DB_LEN);

  logic            sync1;
  logic            sync2;
  logic            level_q;
  logic [DB_W-1:0] db_cnt;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: DB_LEN consecutive disagreeing samples flip the level; level_q feeds edge detect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level   <= 1'b0;
      level_q <= 1'b0;
      db_cnt  <= '0;
    end else begin
      level_q <= level;
      if (tick) begin
        if (sync2 != level) begin
          if (db_cnt == DB_W'(DB_LEN - 1)) begin
            level  <= ~level;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  assign press_set   = level & ~level_q;
  assign release_set = ~level & level_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RPT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int RPT_W   = cnt_width(RPT_MAX);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             rpt_hit;

  // The first repeat waits HOLD_TICKS, later ones REPEAT_TICKS.
  always_comb begin
    rpt_hit = rpt_armed ? (rpt_cnt == RPT_W'(REPEAT_TICKS - 1))
                        : (rpt_cnt == RPT_W'(HOLD_TICKS - 1));
  end

  assign repeat_set = level & tick & rpt_hit;

  // Hold counter runs only while the debounced level is high; release restarts it.
  always_ff @(posedge clk) begin
    if (!rst || !level) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (tick) begin
      if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: conditions N_BTN buttons and serializes their
// press/release/repeat events onto one valid/ready stream, round-robin.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (adds REPEAT events).
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int SAMPLE_DIV   = 100000,
  parameter int DB_LEN       = 4,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [EVT_TYPE_W-1:0]    evt_type,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     overrun
);

  localparam int ID_W    = $clog2(N_BTN);
  localparam int PRESC_W = cnt_width(SAMPLE_DIV - 1);
  // An out-of-range configuration never samples, so every button stays released.
  localparam bit CFG_OK  = (N_BTN >= 2) && (SAMPLE_DIV >= 2) && (DB_LEN >= 2) &&
                           (HOLD_TICKS >= 1) && (REPEAT_TICKS >= 1);

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [N_BTN-1:0]   press_set, release_set, repeat_set;
  logic [N_BTN-1:0]   pend_press, pend_release, pend_repeat, any_pend;
  logic [N_BTN-1:0]   clr_press, clr_release, clr_repeat;
  logic [ID_W-1:0]    last_id, grant_id, cand;
  logic               found, advance, take;
  evt_type_t          grant_type;
  int                 scan_idx;

  // Sample-tick prescaler shared by every button.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
    end else if (presc == PRESC_W'(SAMPLE_DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = CFG_OK && (presc == PRESC_W'(SAMPLE_DIV - 1));

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_conditioner #(
      .DB_LEN      (DB_LEN)
`ifdef BUTTON_AUTO_REPEAT_EN
      ,
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
`endif
    ) u_cond (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_in[i]),
      .tick       (tick),
      .level      (btn_level[i]),
      .press_set  (press_set[i]),
      .release_set(release_set[i])
`ifdef BUTTON_AUTO_REPEAT_EN
      ,
      .repeat_set (repeat_set[i])
`endif
    );
  end

`ifndef BUTTON_AUTO_REPEAT_EN
  assign repeat_set  = '0;
  assign pend_repeat = '0;
`endif

  assign any_pend = pend_press | pend_release | pend_repeat;
  assign advance  = !evt_valid || evt_ready;
  assign take     = advance && found;

  // Round-robin scan starting just after the last granted button, wrapping.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    scan_idx = 0;
    cand     = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      scan_idx = int'(last_id) + k;
      if (scan_idx >= N_BTN) scan_idx = scan_idx - N_BTN;
      cand = ID_W'(scan_idx);
      if (!found && any_pend[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  // Per-button priority PRESS, REPEAT, RELEASE, and the clear for the granted bit.
  always_comb begin
    grant_type  = EVT_RELEASE;
    clr_press   = '0;
    clr_release = '0;
    clr_repeat  = '0;
    if (pend_press[grant_id]) begin
      grant_type = EVT_PRESS;
    end else if (pend_repeat[grant_id]) begin
      grant_type = EVT_REPEAT;
    end
    if (take) begin
      case (grant_type)
        EVT_PRESS:  clr_press[grant_id]   = 1'b1;
        EVT_REPEAT: clr_repeat[grant_id]  = 1'b1;
        default:    clr_release[grant_id] = 1'b1;
      endcase
    end
  end

  // A set on a bit that is already pending and not leaving this cycle loses an event.
  assign overrun = |((press_set   & pend_press   & ~clr_press)   |
                     (release_set & pend_release & ~clr_release) |
                     (repeat_set  & pend_repeat  & ~clr_repeat));

  // Pending bits: a new set beats a same-cycle grant clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_press   <= '0;
      pend_release <= '0;
    end else begin
      pend_press   <= press_set   | (pend_press   & ~clr_press);
      pend_release <= release_set | (pend_release & ~clr_release);
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  // Repeat pending bits, only present when auto-repeat is built.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_repeat <= '0;
    end else begin
      pend_repeat <= repeat_set | (pend_repeat & ~clr_repeat);
    end
  end
`endif

  // Output register: loads a new grant when empty or when the current event transfers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= '0;
      last_id   <= ID_W'(N_BTN - 1);
    end else if (advance) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_id    <= grant_id;
        evt_type  <= grant_type;
        last_id   <= grant_id;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
